button_led_array: RTL and testbench

- Parametrised, multi-channel successor to the single push-button-to-LED path.
- Each channel does the following, in order:
  - synchronises its raw BUTTON input;
  - debounces it;
  - drives its LED in one of three selectable modes: follow, toggle, pulse-stretch.
- The block sits between board push-buttons and board LEDs in the setup/test design.
- It also exports the clean debounced level and a one-cycle press strobe for downstream game logic.

---
 rtl/button_led_array.sv | 109 ++++++++++
 tb/tb_button_led_array.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/button_led_array.sv
// Multi-channel push-button front end: per channel a two-flop synchroniser,
// a debouncer with press strobe, and an LED driver (follow, toggle or pulse-stretch).
module button_led_array #(
  parameter int CHANNELS          = 4,
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int MODE              = 0,
  parameter int STRETCH_CYCLES    = 25000000,
  parameter bit BUTTON_ACTIVE_LOW = 1'b0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] BUTTON,
  output logic [CHANNELS-1:0] LED,
  output logic [CHANNELS-1:0] STATE,
  output logic [CHANNELS-1:0] PRESS
);

  typedef enum logic [1:0] {
    LED_FOLLOW  = 2'd0,
    LED_TOGGLE  = 2'd1,
    LED_STRETCH = 2'd2
  } led_mode_e;

  // Unrecognised MODE values fall back to follow.
  localparam led_mode_e LED_MODE = (MODE == 1) ? LED_TOGGLE :
                                   (MODE == 2) ? LED_STRETCH : LED_FOLLOW;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic            s1;
    logic            s2;
    logic            state_q;
    logic            press_q;
    logic [DB_W-1:0] db_cnt;
    logic            accept;

    always_comb accept = (s2 != state_q) && (db_cnt == DB_LAST);

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        state_q <= 1'b0;
        press_q <= 1'b0;
        db_cnt  <= '0;
      end else begin
        s1      <= BUTTON[i] ^ BUTTON_ACTIVE_LOW;
        s2      <= s1;
        // Strobe rises in the same cycle STATE first reads 1.
        press_q <= accept & s2;
        if (s2 == state_q) begin
          db_cnt <= '0;
        end else if (accept) begin
          state_q <= s2;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

    assign STATE[i] = state_q;
    assign PRESS[i] = press_q;

    if (LED_MODE == LED_TOGGLE) begin : g_toggle
      logic toggle_q;

      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          toggle_q <= 1'b0;
        end else if (press_q) begin
          toggle_q <= ~toggle_q;
        end
      end

      assign LED[i] = toggle_q;
    end else if (LED_MODE == LED_STRETCH) begin : g_stretch
      localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
      localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYCLES);

      logic [ST_W-1:0] st_cnt;
      logic            st_led;

      // LED drops on the edge the counter leaves 1, giving exactly
      // STRETCH_CYCLES lit cycles; a new press reloads without a gap.
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          st_cnt <= '0;
          st_led <= 1'b0;
        end else if (press_q) begin
          st_cnt <= ST_LOAD;
          st_led <= 1'b1;
        end else if (st_cnt != '0) begin
          st_cnt <= st_cnt - ST_W'(1);
          st_led <= (st_cnt != ST_W'(1));
        end else begin
          st_led <= 1'b0;
        end
      end

      assign LED[i] = st_led;
    end else begin : g_follow
      assign LED[i] = state_q;
    end
  end

endmodule

// File: tb/tb_button_led_array.sv
// Scoreboard bench for button_led_array: stimulus queues cycle-stamped expected
// {LED,STATE,PRESS} values, a negedge monitor compares them against each DUT.
module tb_button_led_array;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;
  logic [1:0] b0, b1, b2, b3, b4;
  logic [1:0] led0, st0, pr0, led1, st1, pr1, led2, st2, pr2;
  logic [1:0] led3, st3, pr3, led4, st4, pr4;
  logic [5:0] obs [5];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    int         dut;
    logic [5:0] mask;
    logic [5:0] val;
    string      name;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_led_array #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .MODE(0), .STRETCH_CYCLES(3),
                     .BUTTON_ACTIVE_LOW(1'b0))
    u0 (.CLK(clk), .RST_N(rst_n), .BUTTON(b0), .LED(led0), .STATE(st0), .PRESS(pr0));
  button_led_array #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .MODE(1), .STRETCH_CYCLES(3),
                     .BUTTON_ACTIVE_LOW(1'b0))
    u1 (.CLK(clk), .RST_N(rst_n), .BUTTON(b1), .LED(led1), .STATE(st1), .PRESS(pr1));
  button_led_array #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .MODE(2), .STRETCH_CYCLES(3),
                     .BUTTON_ACTIVE_LOW(1'b0))
    u2 (.CLK(clk), .RST_N(rst_n), .BUTTON(b2), .LED(led2), .STATE(st2), .PRESS(pr2));
  button_led_array #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .MODE(2), .STRETCH_CYCLES(14),
                     .BUTTON_ACTIVE_LOW(1'b0))
    u3 (.CLK(clk), .RST_N(rst_n), .BUTTON(b3), .LED(led3), .STATE(st3), .PRESS(pr3));
  button_led_array #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .MODE(0), .STRETCH_CYCLES(3),
                     .BUTTON_ACTIVE_LOW(1'b1))
    u4 (.CLK(clk), .RST_N(rst4_n), .BUTTON(b4), .LED(led4), .STATE(st4), .PRESS(pr4));

  // Layout per DUT: [5:4] LED, [3:2] STATE, [1:0] PRESS.
  assign obs[0] = {led0, st0, pr0};
  assign obs[1] = {led1, st1, pr1};
  assign obs[2] = {led2, st2, pr2};
  assign obs[3] = {led3, st3, pr3};
  assign obs[4] = {led4, st4, pr4};

  function automatic void expect_span(int d, int c0, int c1, logic [5:0] m,
                                      logic [5:0] v, string n);
    for (int c = c0; c <= c1; c++) begin
      exp_t e;
      e.cyc  = c;
      e.dut  = d;
      e.mask = m;
      e.val  = v;
      e.name = n;
      sbq.push_back(e);
    end
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        logic [5:0] got;
        got = obs[sbq[i].dut] & sbq[i].mask;
        checks++;
        if (got !== (sbq[i].val & sbq[i].mask)) begin
          errors++;
          $display("FAIL %s dut%0d cycle %0d: got %b expected %b (mask %b)",
                   sbq[i].name, sbq[i].dut, cyc, got, sbq[i].val & sbq[i].mask, sbq[i].mask);
        end
        sbq.delete(i);
      end else if (sbq[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s dut%0d missed cycle %0d", sbq[i].name, sbq[i].dut, sbq[i].cyc);
        sbq.delete(i);
      end
    end
  end

  initial begin
    int   e;
    int   r;
    logic l;

    rst_n  = 1'b0;
    rst4_n = 1'b0;
    b0 = 2'b00; b1 = 2'b00; b2 = 2'b00; b3 = 2'b00;
    b4 = 2'b11;
    step(3);
    for (int d = 0; d < 5; d++) expect_span(d, cyc, cyc, '1, '0, "reset");
    rst_n  = 1'b1;
    rst4_n = 1'b1;
    expect_span(4, cyc + 1, cyc + 9, 6'b001100, '0, "al_idle_state");

    // Clean press, follow mode
    e = cyc; b0 = 2'b01;
    expect_span(0, e + 1, e + 5,  '1, '0,        "a_wait");
    expect_span(0, e + 6, e + 6,  '1, 6'b010101, "a_rise");
    expect_span(0, e + 7, e + 10, '1, 6'b010100, "a_hold");
    step(10);
    e = cyc; b0 = 2'b00;
    expect_span(0, e + 1, e + 5, '1, 6'b010100, "a_rel_wait");
    expect_span(0, e + 6, e + 9, '1, '0,        "a_released");
    step(10);

    // Bounce rejection then a genuine press
    e = cyc;
    expect_span(0, e + 1, e + 16, '1, '0, "bounce_reject");
    b0 = 2'b01; step(3);
    b0 = 2'b00; step(1);
    b0 = 2'b01; step(3);
    b0 = 2'b00; step(9);
    e = cyc; b0 = 2'b01;
    expect_span(0, e + 1, e + 5, '1, '0,        "bounce_wait");
    expect_span(0, e + 6, e + 6, '1, 6'b010101, "bounce_accept");
    expect_span(0, e + 7, e + 8, '1, 6'b010100, "bounce_hold");
    step(8);
    e = cyc; b0 = 2'b00;
    expect_span(0, e + 6, e + 8, '1, '0, "bounce_release");
    step(10);

    // Simultaneous channels
    e = cyc; b0 = 2'b11;
    expect_span(0, e + 5, e + 5,  '1, '0,        "sim_wait");
    expect_span(0, e + 6, e + 6,  '1, 6'b111111, "sim_rise");
    expect_span(0, e + 7, e + 10, '1, 6'b111100, "sim_hold");
    step(10);
    e = cyc; b0 = 2'b10;
    expect_span(0, e + 5, e + 5, '1, 6'b111100, "sim_rel_wait");
    expect_span(0, e + 6, e + 9, '1, 6'b101000, "sim_ch1_kept");
    step(10);

    // Toggle mode, channel 1
    for (int k = 0; k < 3; k++) begin
      l = (k % 2) == 1;
      e = cyc; b1 = 2'b10;
      expect_span(1, e + 5, e + 5, 6'b101010, {l, 5'b00000},                   "tog_before");
      expect_span(1, e + 6, e + 6, 6'b101010, {l, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}, "tog_press");
      expect_span(1, e + 7, e + 7, 6'b101010, {~l, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, "tog_flip");
      expect_span(1, e + 7, e + 7, 6'b010101, '0, "tog_ch0_idle");
      step(10);
      e = cyc; b1 = 2'b00;
      expect_span(1, e + 6, e + 8, 6'b101010, {~l, 5'b00000}, "tog_release");
      step(10);
    end

    // Pulse-stretch, single press
    e = cyc; b2 = 2'b01;
    expect_span(2, e + 6,  e + 6,  6'b010001, 6'b000001, "str_press");
    expect_span(2, e + 7,  e + 9,  6'b010001, 6'b010000, "str_on");
    expect_span(2, e + 10, e + 13, 6'b010001, '0,        "str_off");
    step(8); b2 = 2'b00; step(12);

    // Pulse-stretch retrigger (longer stretch so a second press fits inside it)
    e = cyc; b3 = 2'b01;
    expect_span(3, e + 6,  e + 6,  6'b010001, 6'b000001, "rt_press1");
    expect_span(3, e + 7,  e + 17, 6'b010001, 6'b010000, "rt_on1");
    expect_span(3, e + 18, e + 18, 6'b010001, 6'b010001, "rt_press2");
    expect_span(3, e + 19, e + 32, 6'b010001, 6'b010000, "rt_on2");
    expect_span(3, e + 33, e + 35, 6'b010001, '0,        "rt_off");
    step(6);  b3 = 2'b00;
    step(6);  b3 = 2'b01;
    step(30); b3 = 2'b00;
    step(10);

    // Active-low pins with mid-operation reset
    e = cyc; b4 = 2'b10;
    expect_span(4, e + 5, e + 5,  '1, '0,        "al_wait");
    expect_span(4, e + 6, e + 6,  '1, 6'b010101, "al_rise");
    expect_span(4, e + 7, e + 10, '1, 6'b010100, "al_hold");
    step(10);
    rst4_n = 1'b0;
    step(1);
    r = cyc;
    expect_span(4, r, r, '1, '0, "al_reset");
    rst4_n = 1'b1;
    expect_span(4, r + 1, r + 5, '1, '0,        "al_post_reset");
    expect_span(4, r + 6, r + 6, '1, 6'b010101, "al_rerise");
    expect_span(4, r + 7, r + 8, '1, 6'b010100, "al_rehold");
    step(10);

    step(3);
    while (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d never checked at cycle %0d", sbq[0].name, sbq[0].dut, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
